// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// The LSU_MISALIGN_TRAP_EN build uses is_misaligned() to trap before the bus request.
package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_e;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  // Size code 2'b11 behaves as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return offset[0];
      default: return offset != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables, store-data replication and
// load-data shift plus sign/zero extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DataWidth = 32
) (
  input  logic [1:0]           i_size,
  input  logic [1:0]           i_offset,
  input  logic                 i_unsigned,
  input  logic [DataWidth-1:0] i_wdata,
  input  logic [DataWidth-1:0] i_rdata,
  output logic [3:0]           o_be,
  output logic [DataWidth-1:0] o_wdata,
  output logic [DataWidth-1:0] o_rdata
);

  logic [DataWidth-1:0] w_shifted;
  logic                 w_sign_b;
  logic                 w_sign_h;

  assign w_shifted = i_rdata >> {i_offset, 3'b000};
  assign w_sign_b  = ~i_unsigned & w_shifted[7];
  assign w_sign_h  = ~i_unsigned & w_shifted[15];

  // Lane offsets past the top byte simply fall off the 4-bit enable mask.
  always_comb begin
    o_be    = BE_W;
    o_wdata = i_wdata;
    o_rdata = w_shifted;
    case (i_size)
      SIZE_B: begin
        o_be    = BE_B << i_offset;
        o_wdata = {(DataWidth/8){i_wdata[7:0]}};
        o_rdata = {{(DataWidth-8){w_sign_b}}, w_shifted[7:0]};
      end
      SIZE_H: begin
        o_be    = BE_H << i_offset;
        o_wdata = {(DataWidth/16){i_wdata[15:0]}};
        o_rdata = {{(DataWidth-16){w_sign_h}}, w_shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one outstanding request, IDLE/REQ/WAIT/RESP handshake FSM.
// Define LSU_MISALIGN_TRAP_EN to answer misaligned requests with err_o instead of a bus access.
module lsu
  import lsu_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic                 we_i,
  input  logic [1:0]           size_i,
  input  logic                 unsigned_i,
  output logic                 rsp_valid_o,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 err_o,
  output logic                 busy_o,
  output logic                 mem_req_o,
  input  logic                 mem_gnt_i,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic                 mem_we_o,
  output logic [3:0]           mem_be_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  input  logic                 mem_rvalid_i,
  input  logic [DataWidth-1:0] mem_rdata_i
);

  state_e               r_state;
  logic [AddrWidth-1:0] r_addr;
  logic [DataWidth-1:0] r_wdata;
  logic                 r_we;
  logic [1:0]           r_size;
  logic                 r_unsigned;
  logic                 r_mem_req;
  logic                 r_rsp_valid;
  logic [DataWidth-1:0] r_rdata;
  logic [DataWidth-1:0] w_rdata_ext;

  lsu_align #(
    .DataWidth(DataWidth)
  ) u_align (
    .i_size    (r_size),
    .i_offset  (r_addr[1:0]),
    .i_unsigned(r_unsigned),
    .i_wdata   (r_wdata),
    .i_rdata   (mem_rdata_i),
    .o_be      (mem_be_o),
    .o_wdata   (mem_wdata_o),
    .o_rdata   (w_rdata_ext)
  );

  assign req_ready_o = (r_state == IDLE);
  assign busy_o      = (r_state != IDLE);
  assign mem_req_o   = r_mem_req;
  assign mem_addr_o  = {r_addr[AddrWidth-1:2], 2'b00};
  assign mem_we_o    = r_we;
  assign rsp_valid_o = r_rsp_valid;
  assign rdata_o     = r_rdata;

`ifdef LSU_MISALIGN_TRAP_EN
  logic r_err;
  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

  // rsp_valid (and err) are set on the edge entering RESP and cleared on the next.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_size      <= 2'b00;
      r_unsigned  <= 1'b0;
      r_mem_req   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      r_err       <= 1'b0;
`endif
    end else begin
      r_rsp_valid <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      r_err       <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (req_valid_i) begin
            r_addr     <= addr_i;
            r_wdata    <= wdata_i;
            r_we       <= we_i;
            r_size     <= size_i;
            r_unsigned <= unsigned_i;
`ifdef LSU_MISALIGN_TRAP_EN
            if (is_misaligned(size_i, addr_i[1:0])) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_err       <= 1'b1;
            end else
`endif
            begin
              r_state   <= REQ;
              r_mem_req <= 1'b1;
            end
          end
        end
        REQ: begin
          if (mem_gnt_i) begin
            r_mem_req <= 1'b0;
            if (r_we) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
            end else if (mem_rvalid_i) begin
              r_rdata     <= w_rdata_ext;
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_rvalid_i) begin
            r_rdata     <= w_rdata_ext;
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: stimulus pushes expected bus and response items,
// a memory responder and a response monitor pop and compare them.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i, req_ready_o, we_i, unsigned_i;
  logic [31:0] addr_i, wdata_i;
  logic [1:0]  size_i;
  logic        rsp_valid_o, err_o, busy_o;
  logic [31:0] rdata_o;
  logic        mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]  mem_be_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic        we;
    int          gd;
    int          rd;
    logic [31:0] word;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } cfg_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
  } rsp_t;

  cfg_t        cfg_q[$];
  rsp_t        rsp_q[$];
  logic [31:0] m_last = 32'h0;

  lsu dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .we_i        (we_i),
    .size_i      (size_i),
    .unsigned_i  (unsigned_i),
    .rsp_valid_o (rsp_valid_o),
    .rdata_o     (rdata_o),
    .err_o       (err_o),
    .busy_o      (busy_o),
    .mem_req_o   (mem_req_o),
    .mem_gnt_i   (mem_gnt_i),
    .mem_addr_o  (mem_addr_o),
    .mem_we_o    (mem_we_o),
    .mem_be_o    (mem_be_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i (mem_rdata_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired or unexpected event (t=%0t)", nm, $time);
  endtask

  // Reference model: plain arithmetic on byte lanes.
  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [1:0] off);
    int b;
    if (sz == 2'd0)      b = 1 << off;
    else if (sz == 2'd1) b = 3 << off;
    else                 b = 15;
    return 4'(b & 15);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] w);
    if (sz == 2'd0) return {24'h0, w[7:0]} * 32'h0101_0101;
    if (sz == 2'd1) return {16'h0, w[15:0]} * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic [1:0] off,
                                         input logic u, input logic [31:0] word);
    logic [31:0] s;
    s = word >> (8 * off);
    if (sz == 2'd0) begin
      s = s & 32'hFF;
      if (!u && s >= 32'h80) s = s + 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      s = s & 32'hFFFF;
      if (!u && s >= 32'h8000) s = s + 32'hFFFF_0000;
    end
    return s;
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  function automatic logic m_mis(input logic [1:0] sz, input logic [1:0] off);
    return (sz == 2'd1 && off[0]) || (sz >= 2'd2 && off != 2'd0);
  endfunction
`endif

  task automatic drive_idle_garbage();
    req_valid_i = 1'b0;
    addr_i      = $urandom;
    wdata_i     = $urandom;
    we_i        = 1'($urandom_range(0, 1));
    size_i      = 2'($urandom_range(0, 3));
    unsigned_i  = 1'($urandom_range(0, 1));
  endtask

  // Called at a negedge; presents one request for exactly one cycle.
  task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic w,
                       input logic [1:0] sz, input logic u, input int gd, input int rd,
                       input logic [31:0] word);
    cfg_t c;
    rsp_t r;
    int   t;
    t = 0;
    while (!req_ready_o && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready_o) begin
      fail_now("ready_timeout");
      return;
    end
    req_valid_i = 1'b1;
    addr_i      = a;
    wdata_i     = wd;
    we_i        = w;
    size_i      = sz;
    unsigned_i  = u;
    r.acc = cyc;
    r.err = 1'b0;
    r.rdata = m_last;
    r.lat = 1;
`ifdef LSU_MISALIGN_TRAP_EN
    if (m_mis(sz, a[1:0])) begin
      r.err = 1'b1;
      r.lat = 1;
    end else
`endif
    begin
      c.we    = w;
      c.gd    = gd;
      c.rd    = rd;
      c.word  = word;
      c.addr  = {a[31:2], 2'b00};
      c.be    = m_be(sz, a[1:0]);
      c.wdata = m_wdata(sz, wd);
      cfg_q.push_back(c);
      if (!w) m_last = m_load(sz, a[1:0], u, word);
      r.rdata = m_last;
      r.lat   = 2 + gd + (w ? 0 : rd);
    end
    rsp_q.push_back(r);
    @(negedge clk);
    drive_idle_garbage();
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((rsp_q.size() != 0 || !req_ready_o) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) fail_now("idle_timeout");
  endtask

  // Memory responder: grants after cfg.gd cycles, returns read data cfg.rd cycles later.
  cfg_t cur;
  bit   active  = 1'b0;
  bit   in_wait = 1'b0;
  int   g_cnt   = 0;
  int   r_cnt   = 0;

  always @(negedge clk) begin
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = $urandom;
    if (!rst_n) begin
      active  = 1'b0;
      in_wait = 1'b0;
    end else if (in_wait) begin
      if (r_cnt == cur.rd) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = cur.word;
        in_wait      = 1'b0;
      end else begin
        r_cnt++;
      end
    end else if (mem_req_o) begin
      if (!active) begin
        if (cfg_q.size() != 0) begin
          cur = cfg_q.pop_front();
        end else begin
          fail_now("mem_req_unexpected");
          cur.we = mem_we_o; cur.gd = 0; cur.rd = 0; cur.word = 32'h0;
          cur.addr = mem_addr_o; cur.be = mem_be_o; cur.wdata = mem_wdata_o;
        end
        active = 1'b1;
        g_cnt  = 0;
      end
      chk("mem_addr", mem_addr_o, cur.addr);
      chk("mem_be", 32'(mem_be_o), 32'(cur.be));
      chk("mem_we", 32'(mem_we_o), 32'(cur.we));
      if (cur.we) chk("mem_wdata", mem_wdata_o, cur.wdata);
      if (g_cnt == cur.gd) begin
        mem_gnt_i = 1'b1;
        active    = 1'b0;
        if (!cur.we) begin
          if (cur.rd == 0) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = cur.word;
          end else begin
            in_wait = 1'b1;
            r_cnt   = 1;
          end
        end
      end else begin
        g_cnt++;
      end
    end else if ($urandom_range(0, 3) == 0) begin
      mem_gnt_i    = 1'b1;
      mem_rvalid_i = 1'b1;
    end
  end

  // Response monitor.
  int busy_cnt = 0;
  always @(negedge clk) begin : mon
    rsp_t e;
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (busy_o) busy_cnt++;
      if (rsp_valid_o) begin
        if (rsp_q.size() == 0) begin
          fail_now("rsp_unexpected");
        end else begin
          e = rsp_q.pop_front();
          chk("rsp_rdata", rdata_o, e.rdata);
          chk("rsp_err", 32'(err_o), 32'(e.err));
          chk("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
          chk("busy_cycles", 32'(busy_cnt), 32'(e.lat));
          chk("ready_in_resp", 32'(req_ready_o), 32'h0);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic reset_checks(input string tag);
    chk({tag, "_mem_req"}, 32'(mem_req_o), 32'h0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'h0);
    chk({tag, "_err"}, 32'(err_o), 32'h0);
    chk({tag, "_rdata"}, rdata_o, 32'h0);
    chk({tag, "_ready"}, 32'(req_ready_o), 32'h1);
    chk({tag, "_busy"}, 32'(busy_o), 32'h0);
  endtask

  task automatic pulse_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 reset_checks(tag);
    cfg_q.delete();
    rsp_q.delete();
    m_last = 32'h0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    drive_idle_garbage();
    req_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    reset_checks("por");
    rst_n = 1'b1;
    @(negedge clk);

    // Word store with two stall cycles on grant.
    issue(32'h100, 32'hDEADBEEF, 1'b1, 2'b10, 1'b0, 2, 0, 32'h0);
    // Signed and unsigned byte loads from the top lane.
    issue(32'h203, 32'h0, 1'b0, 2'b00, 1'b0, 0, 1, 32'h80FF_1234);
    wait_idle();
    chk("lb_signed_value", rdata_o, 32'hFFFF_FF80);
    issue(32'h203, 32'h0, 1'b0, 2'b00, 1'b1, 1, 0, 32'h80FF_1234);
    wait_idle();
    chk("lbu_value", rdata_o, 32'h0000_0080);
    // Halfword store, then check a store leaves rdata_o alone.
    issue(32'h0A, 32'h0000_ABCD, 1'b1, 2'b01, 1'b0, 0, 0, 32'h0);
    wait_idle();
    chk("store_keeps_rdata", rdata_o, 32'h0000_0080);
    // Load with grant and rvalid together.
    issue(32'h44, 32'h0, 1'b0, 2'b10, 1'b0, 0, 0, 32'h1357_9BDF);
    // Misaligned word load, and size code 3 as a word.
    issue(32'h102, 32'h0, 1'b0, 2'b10, 1'b0, 0, 2, 32'hCAFE_F00D);
    issue(32'h208, 32'h0, 1'b0, 2'b11, 1'b1, 1, 1, 32'h8765_4321);
    issue(32'h301, 32'h0, 1'b0, 2'b01, 1'b0, 0, 0, 32'h00F0_8000);
    wait_idle();

    // Reset while a request is waiting for grant: mem_req_o must drop at once.
    issue(32'h400, 32'h0, 1'b0, 2'b10, 1'b0, 8, 0, 32'h1111_1111);
    chk("req_before_reset", 32'(mem_req_o), 32'h1);
    pulse_reset("rst_in_req");
    // Reset while waiting for read data.
    issue(32'h500, 32'h0, 1'b0, 2'b10, 1'b0, 0, 8, 32'h2222_2222);
    @(negedge clk);
    chk("in_wait_busy", 32'(busy_o), 32'h1);
    pulse_reset("rst_in_wait");
    issue(32'h602, 32'h0, 1'b0, 2'b01, 1'b0, 1, 2, 32'hA5C3_0000);
    wait_idle();
    chk("load_after_reset", rdata_o, 32'hFFFF_A5C3);

    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue($urandom & 32'h0000_0FFF, $urandom, 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end
    wait_idle();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameters SHALL be: DataWidth, default 32, data path width; AddrWidth, default 32, byte address width.
REQ-002 clk_i  input  1  single core clock; all state is updated on its rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous and active-low.
REQ-004 req_valid_i  input  1  core requests a load/store; req_ready_o  output  1  LSU accepts the request (high only in IDLE).
REQ-005 addr_i  input  AddrWidth  byte address (ALU result_o); wdata_i  input  DataWidth  store data (rs2).
REQ-006 we_i  input  1  1 selects store, 0 selects load; size_i  input  2  00 selects byte, 01 halfword, 10 word, 11 treated as word; unsigned_i  input  1  zero-extends load data.
REQ-007 rsp_valid_o  output  1  one-cycle completion pulse; rdata_o  output  DataWidth  extended load data; err_o  output  1  misaligned access; busy_o  output  1  core stall (state != IDLE).
REQ-008 mem_req_o  output  1; mem_gnt_i  input  1; mem_addr_o  output  AddrWidth, word-aligned; mem_we_o  output  1; mem_be_o  output  4; mem_wdata_o  output  DataWidth.
REQ-009 mem_rvalid_i  input  1  read data valid; mem_rdata_i  input  DataWidth  read word.

Function
REQ-010 FSM states SHALL be IDLE, REQ, WAIT and RESP, encoded as an enum.
REQ-011 IDLE -> REQ when req_valid_i=1: latch addr, wdata, we, size and unsigned into request registers in that cycle.
REQ-012 In REQ, mem_req_o SHALL be 1 and mem_addr/we/be/wdata SHALL be held stable until mem_gnt_i=1.
REQ-013 REQ -> RESP on mem_gnt_i for stores; for loads, REQ -> WAIT on mem_gnt_i, or REQ -> RESP if mem_rvalid_i is also 1 in the same cycle.
REQ-014 WAIT -> RESP on mem_rvalid_i=1, registering the extracted load data in that cycle.
REQ-015 In RESP, rsp_valid_o SHALL be 1 for exactly one cycle; RESP -> IDLE unconditionally.
REQ-016 Minimum latency, measured from the accept edge to rsp_valid_o: store 2 cycles; load 2 cycles (gnt and rvalid in the same cycle); each stall cycle adds one.
REQ-017 mem_addr_o SHALL equal the latched address with bits [1:0] cleared.
REQ-018 Byte enables: byte 0001<<a[1:0]; halfword 0011<<a[1:0]; word 1111; mem_be_o SHALL be driven for loads as well.
REQ-019 Store data: byte lanes replicate wdata[7:0] four times; halfword replicates wdata[15:0] twice; word passes through unchanged.
REQ-020 Load data SHALL be mem_rdata_i shifted right by a[1:0]*8, then sign-extended (unsigned_i=0) or zero-extended (unsigned_i=1) from 8 or 16 bits.
REQ-021 rdata_o SHALL hold its value until the next load completes; stores SHALL leave rdata_o unchanged.
REQ-022 mem_rvalid_i SHALL be ignored outside WAIT and REQ; mem_gnt_i SHALL be ignored outside REQ.
REQ-023 Misaligned access is defined as a halfword with a[0]=1, or a word with a[1:0]!=0.

Reset
REQ-024 While rst_ni=0: state=IDLE; mem_req_o, rsp_valid_o and err_o =0; rdata_o=0; request registers=0; req_ready_o=1.
REQ-025 Reset asserted mid-transaction SHALL drop mem_req_o immediately (asynchronously) and discard the transaction without any response.

Configuration
REQ-026 Macro LSU_MISALIGN_TRAP_EN SHALL be the configuration switch.
REQ-027 With the macro defined, a misaligned request SHALL go IDLE -> RESP with no mem_req_o, err_o=1 during RESP, and rdata_o unchanged.
REQ-028 With the macro undefined, a misaligned request SHALL proceed normally using the truncated lane offset, and err_o SHALL be tied to 0.

Structure
REQ-029 Package lsu_pkg SHALL hold the size enum (SIZE_B, SIZE_H, SIZE_W), the FSM state enum and the byte-enable constants.
REQ-030 Sub-module lsu_align SHALL be purely combinational, producing be, replicated wdata and extended rdata; the FSM and registers stay in lsu.

Verification
REQ-031 Store word: addr 0x100, wdata 0xDEADBEEF, gnt delayed 2 cycles -> mem_addr 0x100, be 1111, held stable; rsp_valid_o 4 cycles after accept.
REQ-032 Load byte signed: addr 0x203, mem_rdata 0x80FF_1234 -> be 1000, rdata_o 0xFFFFFF80; with unsigned_i=1 -> 0x00000080.
REQ-033 Store halfword: addr 0x0A, wdata 0x0000ABCD -> mem_addr 0x08, be 1100, mem_wdata 0xABCDABCD.
REQ-034 Load with gnt and rvalid in the same cycle -> WAIT skipped, rsp_valid_o on the next cycle, busy_o high for 2 cycles.
REQ-035 Word load at 0x102 -> with LSU_MISALIGN_TRAP_EN: no mem_req_o, err_o=1 with rsp_valid_o; without the macro: mem_addr 0x100, be 1111.
REQ-036 rst_ni pulsed low while in WAIT -> mem_req_o=0, state IDLE, no rsp_valid_o; a following load completes correctly.
